// File: rtl/rv32i_regfile_pkg.sv
// rv32i_regfile_pkg: shared types, defaults and port-slicing helper for the multi-port register file
package rv32i_regfile_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  localparam int DEF_XLEN = 32;
  localparam int DEF_NREGS = 32;
  localparam int X0 = 0;
  function automatic int slice_lsb(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/rv32i_regfile_clr_ctrl.sv
// rv32i_regfile_clr_ctrl: post-reset sweep sequencer that zeroes registers 1..NREGS-1 and then raises ready
module rv32i_regfile_clr_ctrl
  import rv32i_regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  output state_t        state,
  output logic [AW-1:0] ptr,
  output logic          clr_we,
  output logic          ready
);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= AW'(1);
      ready <= 1'b0;
    end else if (state == CLEAR) begin
      if (ptr == AW'(NREGS - 1)) begin
        state <= RUN;
        ready <= 1'b1;
      end else ptr <= ptr + 1'b1;
    end
  end
  assign clr_we = state == CLEAR && !rst;
endmodule

// File: rtl/rv32i_regfile_mp.sv
// rv32i_regfile_mp: parametrised multi-read-port register file with self-clearing sweep after reset.
// Optional RV32I_REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module rv32i_regfile_mp
  import rv32i_regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen,
  input  logic [AW-1:0]       rd,
  input  logic [XLEN-1:0]     din,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic                ready,
  output logic                wr_ack
);
  state_t          state;
  logic [AW-1:0]   ptr;
  logic            clr_we;
  logic            wr;
  logic [XLEN-1:0] mem [NREGS];
  rv32i_regfile_clr_ctrl #(.NREGS(NREGS), .AW(AW)) u_clr (
    .clk(clk),
    .rst(rst),
    .state(state),
    .ptr(ptr),
    .clr_we(clr_we),
    .ready(ready)
  );
  assign wr = state == RUN && wen && rd != AW'(X0);
  always_ff @(posedge clk) begin
    if (rst) wr_ack <= 1'b0;
    else wr_ack <= wr;
  end
  // storage has no reset; the sweep zeroes it, and a write in a reset cycle is dropped
  always_ff @(posedge clk) begin
    if (clr_we) mem[ptr] <= '0;
    else if (wr && !rst) mem[rd] <= din;
  end
  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] a;
      logic          byp;
      assign a = rs_addr[slice_lsb(k, AW) +: AW];
`ifdef RV32I_REGFILE_BYPASS_EN
      assign byp = wr && a == rd;
`else
      assign byp = 1'b0;
`endif
      assign rs_data[slice_lsb(k, XLEN) +: XLEN] =
        (state != RUN || a == AW'(X0)) ? '0 : byp ? din : mem[a];
    end
  endgenerate
endmodule
